adc_emulator: RTL and testbench

Serial-ADC emulator: the responder end of the ADC conversion/readout interface (`cnv_p`, `sck_p`, `sdo_p`) that the ADC pulse generator initiates. It receives the convert strobe and serial clock and returns sample words MSB-first on `sdo_p`, emulating a 16-bit SAR ADC with a fixed busy time. It sits in the 210 MHz domain for on-chip loopback self-test of the ADC capture → memory-map → UART path without the physical converter. It also serves as a bench model.

---
 rtl/adc_pkg.sv | 13 +
 rtl/edge_sync.sv | 35 +++
 rtl/adc_emulator.sv | 153 +++++++++++++++
 tb/tb_adc_emulator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared defaults and FSM state encoding for the serial-ADC emulator.
package adc_pkg;

    localparam int unsigned ADC_DATA_WIDTH  = 16;
    localparam int unsigned ADC_CONV_CYCLES = 140;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        READOUT = 2'd2
    } adc_state_e;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer with a history flop; emits registered one-cycle
// rise/fall pulses for an asynchronous input.
module edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~hist_q;
            fall_q <= ~sync_q[STAGES-1] & hist_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/adc_emulator.sv
// Responder side of a serial SAR-ADC link: convert strobe in, fixed busy time,
// then the captured word shifted out MSB-first on falling serial-clock edges.
module adc_emulator
    import adc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = ADC_DATA_WIDTH,
    parameter int unsigned CONV_CYCLES = ADC_CONV_CYCLES,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk210_p,
    input  logic                  reset_p,
    input  logic                  cnv_p,
    input  logic                  sck_p,
    output logic                  sdo_p,
    input  logic                  pattern_sel_p,
    input  logic [DATA_WIDTH-1:0] sample_data_p,
    input  logic                  overrun_clr_p,
    output logic                  busy_p,
    output logic                  overrun_p,
    output logic [31:0]           conv_count_p
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
    localparam int unsigned CNT_W = $clog2(CONV_CYCLES);

    logic cnv_rise;
    logic cnv_fall_unused;
    logic sck_rise_unused;
    logic sck_fall;

    edge_sync #(.STAGES(SYNC_STAGES)) u_cnv_sync (
        .clk_i  (clk210_p),
        .rst_i  (reset_p),
        .d_i    (cnv_p),
        .rise_o (cnv_rise),
        .fall_o (cnv_fall_unused)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk_i  (clk210_p),
        .rst_i  (reset_p),
        .d_i    (sck_p),
        .rise_o (sck_rise_unused),
        .fall_o (sck_fall)
    );

    adc_state_e            state_q,    state_d;
    logic [CNT_W-1:0]      busy_cnt_q, busy_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q,    shreg_d;
    logic [DATA_WIDTH-1:0] ramp_q,     ramp_d;
    logic [31:0]           count_q,    count_d;
    logic                  sdo_q,      sdo_d;
    logic                  busy_q,     busy_d;
    logic                  overrun_q,  overrun_d;
    logic                  start;
    logic                  set_ovr;

    always_ff @(posedge clk210_p or posedge reset_p) begin
        if (reset_p) begin
            state_q    <= IDLE;
            busy_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ramp_q     <= '0;
            count_q    <= '0;
            sdo_q      <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ramp_q     <= ramp_d;
            count_q    <= count_d;
            sdo_q      <= sdo_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ramp_d     = ramp_q;
        count_d    = count_q;
        sdo_d      = sdo_q;
        busy_d     = busy_q;
        start      = 1'b0;
        set_ovr    = 1'b0;

        case (state_q)
            IDLE: begin
                sdo_d  = 1'b0;
                busy_d = 1'b0;
                start  = cnv_rise;
            end
            CONVERT: begin
                set_ovr = cnv_rise;
                if (busy_cnt_q == '0) begin
                    state_d   = READOUT;
                    busy_d    = 1'b0;
                    sdo_d     = shreg_q[DATA_WIDTH-1];
                    bit_cnt_d = '0;
                end else begin
                    busy_cnt_d = busy_cnt_q - 1'b1;
                end
            end
            READOUT: begin
                // A new strobe beats a simultaneous sck fall: no shift happens.
                if (cnv_rise) begin
                    set_ovr = 1'b1;
                    start   = 1'b1;
                end else if (sck_fall) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = IDLE;
                        sdo_d   = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sdo_d     = shreg_q[DATA_WIDTH-2];
                        shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sdo_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (start) begin
            shreg_d    = pattern_sel_p ? sample_data_p : ramp_q;
            ramp_d     = ramp_q + 1'b1;
            count_d    = count_q + 32'd1;
            busy_cnt_d = CNT_W'(CONV_CYCLES - 1);
            busy_d     = 1'b1;
            sdo_d      = 1'b0;
            state_d    = CONVERT;
        end

        overrun_d = set_ovr ? 1'b1 : (overrun_clr_p ? 1'b0 : overrun_q);
    end

    assign sdo_p        = sdo_q;
    assign busy_p       = busy_q;
    assign overrun_p    = overrun_q;
    assign conv_count_p = count_q;

endmodule

// File: tb/tb_adc_emulator.sv
// Directed/randomised bench for adc_emulator: a default-size instance for the
// protocol checks and a 4-bit, short-busy instance to reach ramp wrap cheaply.
module tb_adc_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cnv, sck, psel, clr, use2;
    logic [15:0] sdata;

    logic cnv_a, sck_a, cnv_b, sck_b;
    assign cnv_a = use2 ? 1'b0 : cnv;
    assign sck_a = use2 ? 1'b1 : sck;
    assign cnv_b = use2 ? cnv  : 1'b0;
    assign sck_b = use2 ? sck  : 1'b1;

    logic        sdo_a, busy_a, ovr_a, sdo_b, busy_b, ovr_b;
    logic [31:0] cnt_a, cnt_b;

    adc_emulator #(.DATA_WIDTH(16), .CONV_CYCLES(140), .SYNC_STAGES(2)) dut (
        .clk210_p      (clk),
        .reset_p       (rst),
        .cnv_p         (cnv_a),
        .sck_p         (sck_a),
        .sdo_p         (sdo_a),
        .pattern_sel_p (psel),
        .sample_data_p (sdata),
        .overrun_clr_p (clr),
        .busy_p        (busy_a),
        .overrun_p     (ovr_a),
        .conv_count_p  (cnt_a)
    );

    adc_emulator #(.DATA_WIDTH(4), .CONV_CYCLES(2), .SYNC_STAGES(2)) dut_small (
        .clk210_p      (clk),
        .reset_p       (rst),
        .cnv_p         (cnv_b),
        .sck_p         (sck_b),
        .sdo_p         (sdo_b),
        .pattern_sel_p (psel),
        .sample_data_p (sdata[3:0]),
        .overrun_clr_p (clr),
        .busy_p        (busy_b),
        .overrun_p     (ovr_b),
        .conv_count_p  (cnt_b)
    );

    logic        sdo_o, busy_o, ovr_o;
    logic [31:0] cnt_o;
    assign sdo_o  = use2 ? sdo_b  : sdo_a;
    assign busy_o = use2 ? busy_b : busy_a;
    assign ovr_o  = use2 ? ovr_b  : ovr_a;
    assign cnt_o  = use2 ? cnt_b  : cnt_a;

    int checks = 0;
    int errors = 0;

    // Reference model: what the converter should have captured and counted.
    int unsigned mask;
    int unsigned ramp_m;
    int unsigned cnt_m;
    logic        ovr_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] model_start();
        logic [15:0] w;
        w      = psel ? 16'(sdata & mask) : 16'(ramp_m);
        ramp_m = (ramp_m + 1) & mask;
        cnt_m  = cnt_m + 1;
        return w;
    endfunction

    task automatic pulse_cnv();
        cnv = 1'b1;
        tick(4);
        cnv = 1'b0;
        tick(4);
    endtask

    task automatic wait_busy_low(input int limit);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall_wait", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic read_bits(input int n, output logic [15:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            w   = {w[14:0], sdo_o};
            sck = 1'b0;
            tick(4);
            sck = 1'b1;
            tick(4);
        end
    endtask

    task automatic full_conversion(input string tag, input int bits);
        logic [15:0] exp_w, got_w;
        exp_w = model_start();
        pulse_cnv();
        wait_busy_low(400);
        read_bits(bits, got_w);
        check(tag, {16'd0, got_w}, {16'd0, exp_w});
        check({tag, "_sdo_idle"}, {31'd0, sdo_o}, 32'd0);
    endtask

    logic [15:0] exp_w, exp_w2, got_w;
    int          rise_cyc, width, hold;

    initial begin
        rst = 1'b1; cnv = 1'b0; sck = 1'b1; psel = 1'b0; clr = 1'b0;
        sdata = '0; use2 = 1'b0;
        mask = 32'hFFFF; ramp_m = 0; cnt_m = 0; ovr_m = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);

        check("rst_sdo",  {31'd0, sdo_o},  32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ovr",  {31'd0, ovr_o},  32'd0);
        check("rst_cnt",  cnt_o,           32'd0);

        for (int i = 0; i < 3; i++) full_conversion("ramp_word", 16);
        check("ramp_cnt", cnt_o, cnt_m);
        check("ramp_ovr", {31'd0, ovr_o}, {31'd0, ovr_m});

        // External pattern; sample changes mid-conversion must not leak through.
        psel  = 1'b1;
        sdata = 16'hA5C3;
        exp_w = model_start();
        cnv = 1'b1;
        @(posedge clk);
        rise_cyc = 0;
        @(negedge clk);
        while (busy_o !== 1'b1 && rise_cyc < 20) begin
            @(posedge clk);
            rise_cyc++;
            @(negedge clk);
        end
        check("busy_rise_lat", rise_cyc, 32'd3);
        width = 1;
        hold  = 1;
        while (busy_o === 1'b1 && width < 400) begin
            @(negedge clk);
            hold++;
            if (hold == 4)  cnv = 1'b0;
            if (hold == 10) sdata = 16'h1234;
            if (busy_o === 1'b1) width++;
        end
        check("busy_width", width, 32'd140);
        check("msb_at_busy_fall", {31'd0, sdo_o}, {31'd0, exp_w[15]});
        read_bits(16, got_w);
        check("ext_word", {16'd0, got_w}, {16'd0, exp_w});

        // Second strobe while converting.
        psel  = 1'b0;
        exp_w = model_start();
        pulse_cnv();
        tick(20);
        pulse_cnv();
        ovr_m = 1'b1;
        check("ovr_conv_busy", {31'd0, busy_o}, 32'd1);
        check("ovr_conv_flag", {31'd0, ovr_o},  {31'd0, ovr_m});
        check("ovr_conv_cnt",  cnt_o,           cnt_m);
        wait_busy_low(400);
        read_bits(16, got_w);
        check("ovr_conv_word", {16'd0, got_w}, {16'd0, exp_w});
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        ovr_m = 1'b0;
        tick(1);
        check("ovr_clear", {31'd0, ovr_o}, {31'd0, ovr_m});

        // Abort a readout after 7 falls.
        psel  = 1'($urandom_range(0, 1));
        sdata = 16'($urandom);
        exp_w = model_start();
        pulse_cnv();
        wait_busy_low(400);
        read_bits(7, got_w);
        check("abort_partial", {25'd0, got_w[6:0]}, {25'd0, exp_w[15:9]});
        sdata  = 16'($urandom);
        exp_w2 = model_start();
        ovr_m  = 1'b1;
        pulse_cnv();
        check("abort_busy", {31'd0, busy_o}, 32'd1);
        check("abort_ovr",  {31'd0, ovr_o},  {31'd0, ovr_m});
        check("abort_cnt",  cnt_o,           cnt_m);
        wait_busy_low(400);
        read_bits(16, got_w);
        check("abort_new_word", {16'd0, got_w}, {16'd0, exp_w2});
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        ovr_m = 1'b0;

        // Random words in both pattern modes.
        for (int i = 0; i < 4; i++) begin
            psel  = 1'($urandom_range(0, 1));
            sdata = 16'($urandom);
            full_conversion("rand_word", 16);
        end
        check("rand_cnt", cnt_o, cnt_m);

        // Asynchronous reset in the middle of a readout.
        psel  = 1'b1;
        sdata = 16'hFFFF;
        exp_w = model_start();
        pulse_cnv();
        wait_busy_low(400);
        read_bits(5, got_w);
        sck = 1'b0;
        tick(1);
        check("pre_rst_sdo", {31'd0, sdo_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        ramp_m = 0; cnt_m = 0; ovr_m = 1'b0;
        check("async_rst_sdo",  {31'd0, sdo_o},  32'd0);
        check("async_rst_busy", {31'd0, busy_o}, 32'd0);
        check("async_rst_cnt",  cnt_o,           cnt_m);
        check("async_rst_ovr",  {31'd0, ovr_o},  {31'd0, ovr_m});
        tick(2);
        rst = 1'b0;
        sck = 1'b1;
        tick(4);
        psel = 1'b0;
        full_conversion("post_rst_word", 16);
        check("post_rst_cnt", cnt_o, cnt_m);

        // Ramp wrap on the 4-bit instance: words 0..15 then 0 again.
        use2 = 1'b1;
        mask = 32'hF; ramp_m = 0; cnt_m = 0; ovr_m = 1'b0;
        psel = 1'b0;
        tick(4);
        for (int i = 0; i < 17; i++) full_conversion("wrap_word", 4);
        check("wrap_cnt", cnt_o, cnt_m);
        check("wrap_ovr", {31'd0, ovr_o}, {31'd0, ovr_m});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
